// File: rtl/nd_pkt_ctrl_if.sv
// Bus bundle for the non-data packet controller: FIFO read side plus the
// decoded-packet valid/ready channel. master = controller, slave = environment.
interface nd_pkt_ctrl_if;
  logic       fifo_empty;
  logic [7:0] fifo_r_data;
  logic       fifo_r_enable;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [3:0] pkt_pid;
  logic [6:0] pkt_addr;
  logic [3:0] pkt_endp;
  logic       pkt_err;
  logic       busy;

  modport master (
    input  fifo_empty, fifo_r_data, pkt_ready,
    output fifo_r_enable, pkt_valid, pkt_pid, pkt_addr, pkt_endp, pkt_err, busy
  );

  modport slave (
    output fifo_empty, fifo_r_data, pkt_ready,
    input  fifo_r_enable, pkt_valid, pkt_pid, pkt_addr, pkt_endp, pkt_err, busy
  );
endinterface

// File: rtl/nd_pkt_ctrl.sv
// Frames USB token/SOF/handshake packets out of the non-data RX FIFO.
// Optional CRC5 validation of token/SOF payloads: define ND_CRC5_CHECK_EN.
module nd_pkt_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic          clk,
  input  logic          rst,
  nd_pkt_ctrl_if.master pkt_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_B1,
    S_RD_B2,
    S_CHK,
    S_EMIT
  } state_t;

  // Only the CRC build needs the top five bits of {B2,B1}.
`ifdef ND_CRC5_CHECK_EN
  localparam int FIELD_W = 16;
`else
  localparam int FIELD_W = 11;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_pid;
  logic [3:0]         w_pid_next;
  logic [FIELD_W-1:0] r_field;
  logic [FIELD_W-1:0] w_field_next;
  logic [TO_W-1:0]    r_to_cnt;
  logic [TO_W-1:0]    w_to_cnt_next;
  logic               r_err;
  logic               w_err_next;
  logic               w_pop;
  logic               w_crc_ok;
  logic               w_emit;

  assign w_pop = ((r_state == S_IDLE) || (r_state == S_RD_B1) || (r_state == S_RD_B2))
                 && !pkt_if.fifo_empty && !rst;

`ifdef ND_CRC5_CHECK_EN
  logic [4:0] w_crc;

  always_comb begin
    w_crc = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (w_crc[4] ^ r_field[i]) w_crc = {w_crc[3:0], 1'b0} ^ 5'b00101;
      else                       w_crc = {w_crc[3:0], 1'b0};
    end
  end

  // Remainder is sent MSB first, so crc[4] lands in field bit 11.
  assign w_crc_ok = (r_field[15:11] == ~{w_crc[0], w_crc[1], w_crc[2], w_crc[3], w_crc[4]});
`else
  assign w_crc_ok = 1'b1;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_pid_next    = r_pid;
    w_field_next  = r_field;
    w_to_cnt_next = r_to_cnt;
    w_err_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_to_cnt_next = '0;
        if (w_pop) begin
          if (pkt_if.fifo_r_data[7:4] != ~pkt_if.fifo_r_data[3:0]) begin
            w_err_next = 1'b1;
          end else begin
            case (pkt_if.fifo_r_data[3:0])
              4'h1, 4'h9, 4'hD, 4'h5: begin
                w_pid_next   = pkt_if.fifo_r_data[3:0];
                w_state_next = S_RD_B1;
              end
              4'h2, 4'hA, 4'hE: begin
                w_pid_next   = pkt_if.fifo_r_data[3:0];
                w_field_next = '0;
                w_state_next = S_EMIT;
              end
              default: w_err_next = 1'b1;
            endcase
          end
        end
      end
      S_RD_B1, S_RD_B2: begin
        if (w_pop) begin
          w_to_cnt_next = '0;
          if (r_state == S_RD_B1) begin
            w_field_next[7:0] = pkt_if.fifo_r_data;
            w_state_next      = S_RD_B2;
          end else begin
            w_field_next[FIELD_W-1:8] = pkt_if.fifo_r_data[FIELD_W-9:0];
            w_state_next              = S_CHK;
          end
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_to_cnt_next = '0;
          w_err_next    = 1'b1;
          w_state_next  = S_IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
        end
      end
      S_CHK: begin
        if (w_crc_ok) begin
          w_state_next = S_EMIT;
        end else begin
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_EMIT: begin
        if (pkt_if.pkt_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pid    <= '0;
      r_field  <= '0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pid    <= w_pid_next;
      r_field  <= w_field_next;
      r_to_cnt <= w_to_cnt_next;
      r_err    <= w_err_next;
    end
  end

  // Outputs are gated by rst so they read zero in the reset cycle itself.
  assign w_emit               = (r_state == S_EMIT) && !rst;
  assign pkt_if.fifo_r_enable = w_pop;
  assign pkt_if.pkt_valid     = w_emit;
  assign pkt_if.pkt_pid       = w_emit ? r_pid : 4'h0;
  assign pkt_if.pkt_addr      = w_emit ? r_field[6:0] : 7'h0;
  assign pkt_if.pkt_endp      = w_emit ? r_field[10:7] : 4'h0;
  assign pkt_if.pkt_err       = r_err && !rst;
  assign pkt_if.busy          = (r_state != S_IDLE) && !rst;

endmodule
